// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Imported by the interface, the bypass mux and the top.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int AW           = $clog2(DEF_NUM_REGS);

  typedef logic [AW-1:0]         reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_if.sv
// Read, write and scoreboard bundle between issue/writeback
// and the register file.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
  logic                          busy_set_en;
  logic [ADDR_W-1:0]             busy_set_addr;
  logic [NUM_REGS-1:0]           busy;
  logic                          init_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output busy_set_en, busy_set_addr,
    input  rd_data, busy, init_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  busy_set_en, busy_set_addr,
    output rd_data, busy, init_done
  );

endinterface

// File: rtl/regfile_bypass_mux.sv
// One read port: stored value, overridden by the highest
// matching write port, forced to zero for register 0.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = AW,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [DATA_W-1:0]             reg_q,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]             rd_data
);

  always_comb begin
    rd_data = reg_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && wr_addr[i] == rd_addr)
        rd_data = wr_data[i];
    end
    if (ZERO_REG != 0 && rd_addr == '0)
      rd_data = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sequence,
// write-to-read bypass and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  rf_state_e           state_q;
  rf_state_e           state_d;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                init_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                run;
  logic [NUM_WR-1:0]   wr_en_r;

  assign run     = (state_q == RUN);
  assign wr_en_r = run ? bus.wr_en : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: if (clr_cnt == ADDR_W'(NUM_REGS - 1)) state_d = RUN;
      RUN:   state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_cnt <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= (state_d == RUN);
      if (state_q == CLEAR)
        clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // Storage has no reset; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        regs[clr_cnt] <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_en_r[i] &&
              !(ZERO_REG != 0 && bus.wr_addr[i] == '0))
            regs[bus.wr_addr[i]] <= bus.wr_data[i];
        end
      end
    end
  end

  // A new producer's set wins over a retiring write's clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else if (run) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en_r[i])
          busy_q[bus.wr_addr[i]] <= 1'b0;
      end
      if (bus.busy_set_en)
        busy_q[bus.busy_set_addr] <= 1'b1;
      if (ZERO_REG != 0)
        busy_q[0] <= 1'b0;
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [DATA_W-1:0] mux_q;

    regfile_bypass_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_mux (
      .rd_addr(bus.rd_addr[j]),
      .reg_q  (regs[bus.rd_addr[j]]),
      .wr_en  (wr_en_r),
      .wr_addr(bus.wr_addr),
      .wr_data(bus.wr_data),
      .rd_data(mux_q)
    );

    assign bus.rd_data[j] = run ? mux_q : '0;
  end

  assign bus.busy      = busy_q;
  assign bus.init_done = init_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequence, bypass,
// zero register, write priority, scoreboard, reset mid-clear.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_ok  = 0;

  always #5 clk = ~clk;

  regfile_if #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)
  ) bus ();

  regfile_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2),
    .NUM_WR(2), .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en         = '0;
    bus.busy_set_en   = 1'b0;
    bus.busy_set_addr = '0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!bus.init_done && n < 100) begin
      tick();
      n++;
    end
  endtask

  int bad;
  int n;

  initial begin
    idle();
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    tick();
    tick();
    chk("rst_init_done", 64'(bus.init_done), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;

    bad = 0;
    for (int k = 0; k < 32; k++) begin
      bus.rd_addr[0] = 5'(k);
      bus.rd_addr[1] = 5'(31 - k);
      #1;
      if (bus.init_done !== 1'b0) bad++;
      if (bus.rd_data[0] !== 32'd0) bad++;
      if (bus.rd_data[1] !== 32'd0) bad++;
      tick();
    end
    chk("clear_zero_and_low", 64'(bad), 64'd0);
    chk("init_after_32", 64'(bus.init_done), 64'd1);

    bad = 0;
    for (int k = 0; k < 32; k++) begin
      bus.rd_addr[0] = 5'(k);
      bus.rd_addr[1] = 5'(31 - k);
      #1;
      if (bus.rd_data[0] !== 32'd0) bad++;
      if (bus.rd_data[1] !== 32'd0) bad++;
    end
    chk("regs_cleared", 64'(bad), 64'd0);
    chk("busy_after_clear", 64'(bus.busy), 64'd0);

    bus.wr_en         = 2'b01;
    bus.wr_addr[0]    = 5'd5;
    bus.wr_data[0]    = 32'hDEADBEEF;
    bus.rd_addr[0]    = 5'd5;
    #1;
    chk("bypass_5", 64'(bus.rd_data[0]), 64'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("stored_5", 64'(bus.rd_data[0]), 64'hDEADBEEF);

    bus.wr_en         = 2'b11;
    bus.wr_addr[0]    = 5'd0;
    bus.wr_addr[1]    = 5'd0;
    bus.wr_data[0]    = 32'h1234;
    bus.wr_data[1]    = 32'h1234;
    bus.busy_set_en   = 1'b1;
    bus.busy_set_addr = 5'd0;
    bus.rd_addr[0]    = 5'd0;
    bus.rd_addr[1]    = 5'd0;
    #1;
    chk("zero_same_cyc", 64'(bus.rd_data[0]), 64'd0);
    tick();
    idle();
    #1;
    chk("zero_next_cyc", 64'(bus.rd_data[1]), 64'd0);
    chk("zero_busy", 64'(bus.busy[0]), 64'd0);

    bus.wr_en      = 2'b11;
    bus.wr_addr[0] = 5'd7;
    bus.wr_addr[1] = 5'd7;
    bus.wr_data[0] = 32'hAAAA;
    bus.wr_data[1] = 32'h5555;
    bus.rd_addr[1] = 5'd7;
    #1;
    chk("prio_bypass", 64'(bus.rd_data[1]), 64'h5555);
    tick();
    idle();
    #1;
    chk("prio_stored", 64'(bus.rd_data[1]), 64'h5555);

    bus.busy_set_en   = 1'b1;
    bus.busy_set_addr = 5'd3;
    tick();
    idle();
    chk("busy_set", 64'(bus.busy), 64'h8);
    bus.wr_en         = 2'b01;
    bus.wr_addr[0]    = 5'd3;
    bus.wr_data[0]    = 32'h33;
    bus.busy_set_en   = 1'b1;
    bus.busy_set_addr = 5'd3;
    tick();
    idle();
    chk("busy_set_wins", 64'(bus.busy[3]), 64'd1);
    bus.wr_en      = 2'b10;
    bus.wr_addr[1] = 5'd3;
    bus.wr_data[1] = 32'h34;
    tick();
    idle();
    chk("busy_clear", 64'(bus.busy), 64'd0);

    bus.wr_en      = 2'b01;
    bus.wr_addr[0] = 5'd20;
    bus.wr_data[0] = 32'hFF;
    tick();
    idle();
    bus.rd_addr[0] = 5'd20;
    #1;
    chk("pre_rst_20", 64'(bus.rd_data[0]), 64'hFF);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("midclr_low", 64'(bus.init_done), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wr_en      = 2'b11;
    bus.wr_addr[0] = 5'd20;
    bus.wr_addr[1] = 5'd21;
    bus.wr_data[0] = 32'h77;
    bus.wr_data[1] = 32'h88;
    bus.busy_set_en   = 1'b1;
    bus.busy_set_addr = 5'd9;
    wait_init(n);
    chk("midclr_cycles", 64'(n), 64'd32);
    idle();
    bus.rd_addr[0] = 5'd20;
    bus.rd_addr[1] = 5'd21;
    #1;
    chk("midclr_20", 64'(bus.rd_data[0]), 64'd0);
    chk("midclr_21", 64'(bus.rd_data[1]), 64'd0);
    chk("midclr_busy", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
